// File: rtl/byte_pack.sv
// Byte-to-word packer: assembles MSB-first byte pairs into 16-bit words held in a
// one-word register with a pop handshake and a sticky overflow flag.
module byte_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in,
    input  logic        wr,
    input  logic        clear,
    input  logic        rd,
    output logic [15:0] out,
    output logic        full,
    output logic        half,
    output logic        overflow
);

    typedef enum logic [0:0] {StIdle, StHalf} state_e;

    state_e      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] out_q, out_d;
    logic        full_q, full_d;
    logic        overflow_q, overflow_d;
    logic        complete;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides and a coincident byte restarts the word
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        complete = 1'b0;
        if (clear) begin
            state_d = wr ? StHalf : StIdle;
            hi_d    = wr ? in : 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wr) begin
                        state_d = StHalf;
                        hi_d    = in;
                    end
                end
                StHalf: begin
                    if (wr) begin
                        state_d  = StIdle;
                        complete = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        half = (state_q == StHalf);
    end

    // Holding register: a pop on the completion edge frees the slot for the new word
    always_comb begin
        out_d      = out_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        if (complete) begin
            if (!full_q || rd) begin
                out_d  = {hi_q, in};
                full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (rd && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q       <= 8'h00;
            out_q      <= 16'h0000;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            out_q      <= out_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_byte_pack.sv
// Directed self-checking bench for byte_pack.
module tb_byte_pack;

    logic        clk;
    logic        reset;
    logic [7:0]  in;
    logic        wr;
    logic        clear;
    logic        rd;
    logic [15:0] out;
    logic        full;
    logic        half;
    logic        overflow;

    int checks;
    int failures;

    byte_pack dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .wr       (wr),
        .clear    (clear),
        .rd       (rd),
        .out      (out),
        .full     (full),
        .half     (half),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input logic do_rd);
        wr = 1'b1;
        in = b;
        rd = do_rd;
        tick();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        in       = 8'h00;
        wr       = 1'b0;
        clear    = 1'b0;
        rd       = 1'b0;
        tick();
        tick();
        check_val("rst_out", out, 16'h0000);
        check_val("rst_full", {15'b0, full}, 16'd0);
        check_val("rst_half", {15'b0, half}, 16'd0);
        check_val("rst_ovf", {15'b0, overflow}, 16'd0);
        #2 reset = 1'b1;
        tick();

        // Basic pack
        put(8'hAB, 1'b0);
        check_val("basic_half1", {15'b0, half}, 16'd1);
        check_val("basic_full0", {15'b0, full}, 16'd0);
        put(8'hCD, 1'b0);
        check_val("basic_out", out, 16'hABCD);
        check_val("basic_full", {15'b0, full}, 16'd1);
        check_val("basic_half0", {15'b0, half}, 16'd0);
        check_val("basic_ovf", {15'b0, overflow}, 16'd0);
        pop();
        check_val("basic_pop_full", {15'b0, full}, 16'd0);
        check_val("basic_pop_out", out, 16'hABCD);

        // Back-to-back stream, pop coincides with second completion
        put(8'hAB, 1'b0);
        put(8'hCD, 1'b0);
        check_val("b2b_out1", out, 16'hABCD);
        put(8'h12, 1'b0);
        check_val("b2b_full_hold", {15'b0, full}, 16'd1);
        put(8'h34, 1'b1);
        check_val("b2b_out2", out, 16'h1234);
        check_val("b2b_full", {15'b0, full}, 16'd1);
        check_val("b2b_ovf", {15'b0, overflow}, 16'd0);
        pop();
        check_val("b2b_pop", {15'b0, full}, 16'd0);

        // Overflow
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        put(8'h33, 1'b0);
        put(8'h44, 1'b0);
        check_val("ovf_out", out, 16'h1122);
        check_val("ovf_full", {15'b0, full}, 16'd1);
        check_val("ovf_flag", {15'b0, overflow}, 16'd1);
        check_val("ovf_half", {15'b0, half}, 16'd0);
        pop();
        put(8'h55, 1'b0);
        put(8'h66, 1'b0);
        check_val("ovf_next_out", out, 16'h5566);
        check_val("ovf_sticky", {15'b0, overflow}, 16'd1);
        pop();

        // Clear alone discards the partial byte
        put(8'hEE, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clr_half", {15'b0, half}, 16'd0);
        put(8'h77, 1'b0);
        put(8'h88, 1'b0);
        check_val("clr_out", out, 16'h7788);
        pop();

        // Clear with a coincident byte starts a new word
        put(8'hEE, 1'b0);
        clear = 1'b1;
        put(8'h99, 1'b0);
        clear = 1'b0;
        check_val("clrwr_half", {15'b0, half}, 16'd1);
        put(8'hAA, 1'b0);
        check_val("clrwr_out", out, 16'h99AA);
        check_val("clrwr_full", {15'b0, full}, 16'd1);

        // Asynchronous reset mid-word with the holding register full
        put(8'hAB, 1'b0);
        check_val("mid_half", {15'b0, half}, 16'd1);
        #2 reset = 1'b0;
        #1;
        check_val("arst_half", {15'b0, half}, 16'd0);
        check_val("arst_full", {15'b0, full}, 16'd0);
        check_val("arst_ovf", {15'b0, overflow}, 16'd0);
        check_val("arst_out", out, 16'h0000);
        tick();
        #2 reset = 1'b1;
        put(8'hCD, 1'b0);
        put(8'hEF, 1'b0);
        check_val("post_rst_out", out, 16'hCDEF);
        check_val("post_rst_ovf", {15'b0, overflow}, 16'd0);
        pop();

        // Idle pops have no effect
        rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("idle_full", {15'b0, full}, 16'd0);
            check_val("idle_out", out, 16'hCDEF);
            check_val("idle_ovf", {15'b0, overflow}, 16'd0);
        end
        rd = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_pack.md
# byte_pack

Byte-to-word packer: the receive-side counterpart of the 16-bit-to-byte serializer in the Ethernet debug path. Collects a stream of 8-bit bytes, most-significant byte first, and presents each completed 16-bit word from a one-word holding register with a valid/pop handshake. Sits between the byte-wide capture logic and word-wide debug consumers. Flags lost words with a sticky overflow bit.

## Interface
- No parameters; widths fixed at 8-bit in, 16-bit out.
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- in  input  8  byte data, sampled when wr=1
- wr  input  1  byte strobe; one byte accepted per cycle with wr=1
- clear  input  1  synchronous discard of a pending partial word
- rd  input  1  pop strobe for the holding register; ignored when full=0
- out  output  16  holding-register word; {first byte, second byte}
- full  output  1  holding register contains an unread word
- half  output  1  one byte of the next word has been captured
- overflow  output  1  sticky: a completed word was dropped

## Operation
- Assembly FSM, two states:
  - IDLE: no partial byte. On wr: hi_reg<=in, go HALF.
  - HALF: hi_reg valid. On wr: word {hi_reg,in} completes, go IDLE.
- half = (state==HALF), registered.
- Word completion in HALF with wr=1:
  - full=0, or full=1 with rd=1: out<={hi_reg,in}, full<=1.
  - full=1 and rd=0: word dropped, out unchanged, overflow<=1, FSM returns IDLE (resynchronize on the next byte).
- rd=1 with full=1 and no completion that cycle: full<=0; out keeps its last value.
- rd=1 with full=0: no effect, no error.
- clear=1: FSM forced to IDLE, hi_reg discarded. If wr=1 in the same cycle, the byte is accepted as a new first byte (FSM -> HALF). clear does not affect full, out or overflow.
- overflow clears only on reset.
- Reset (any time, including mid-word): state=IDLE, hi_reg=0, out=16'h0000, full=0, half=0, overflow=0. No partial word survives reset.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Latency: second byte sampled at edge N -> out valid and full=1 after edge N (visible cycle N+1).
- Throughput: one word every 2 cycles with continuous wr; no stall path, no ready signal. Upstream must not exceed one byte per cycle.
- Pop and completion on the same edge: full stays 1, out takes the new word, no overflow.
- half rises after the edge sampling the first byte, falls after the edge sampling the second byte or clear.
- Reset deassertion: first byte accepted on the first rising edge with reset=1.

## Test plan
- Basic pack: reset, wr with 8'hAB then 8'hCD on consecutive edges -> out=16'hABCD, full=1 one cycle later, half pulses one cycle, overflow=0; rd=1 one cycle -> full=0, out stays 16'hABCD.
- Back-to-back with pop: stream AB,CD,12,34 continuously, rd asserted the cycle full rises -> out 16'hABCD then 16'h1234, full held 1 across the simultaneous pop/complete, overflow=0.
- Overflow: words 16'h1122 and 16'h3344 sent with rd=0 -> out=16'h1122, full=1, overflow=1, half=0 after 8'h44; next bytes 55,66 with prior rd -> out=16'h5566.
- Clear: send 8'hEE, then clear=1 alone, then bytes 77,88 -> out=16'h7788. Repeat with clear=1 and wr=1 (8'h99) together, then 8'hAA -> out=16'h99AA.
- Reset mid-word: send 8'hAB, assert reset=0 asynchronously between edges -> half, full, overflow, out drop to 0 immediately; after release, CD,EF -> out=16'hCDEF.
- Idle pop: rd=1 while full=0 for several cycles -> no output change, overflow=0.
